// File: rtl/rx_frame_controller_pkg.sv
// rtl/rx_frame_controller_pkg.sv - shared state encoding, digit codes and bit-reverse helper
package rx_frame_controller_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } rx_state_e;

  localparam logic [3:0] BLANK_CODE_DEF = 4'b1011;
  localparam logic [3:0] ERR_CODE_DEF   = 4'b1010;

  function automatic logic [15:0] bit_reverse16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = v[15-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_frame_controller_timeout.sv
// rtl/rx_frame_controller_timeout.sv - inter-byte timeout counter with clear and expiry flag
module rx_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Expiry is a level; the frame FSM stops incrementing once it is seen.
  assign expired = (count == LIMIT);

endmodule

// File: rtl/rx_frame_controller.sv
// rtl/rx_frame_controller.sv - pairs received bytes into frames and loads bit-reversed digits
module rx_frame_controller
  import rx_frame_controller_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [3:0] BLANK_CODE     = BLANK_CODE_DEF,
  parameter logic [3:0] ERR_CODE       = ERR_CODE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Rx_DATA,
  input  logic       Rx_VALID,
  input  logic       Rx_FERROR,
  input  logic       Rx_PERROR,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       frame_done,
  output logic       frame_err,
  output logic       err_sticky,
  output logic       busy
);

  rx_state_e   state, state_nxt;
  logic [7:0]  high_byte, high_nxt;
  logic [15:0] digits, digits_nxt;
  logic        done_nxt, err_nxt, sticky_nxt;
  logic        cnt_clear, cnt_inc, expired;
  logic        byte_bad;

  assign byte_bad = Rx_FERROR | Rx_PERROR;

  rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (reset),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      high_byte  <= 8'h00;
      digits     <= {4{BLANK_CODE}};
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_nxt;
      high_byte  <= high_nxt;
      digits     <= digits_nxt;
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
      err_sticky <= sticky_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    high_nxt   = high_byte;
    digits_nxt = digits;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    sticky_nxt = err_sticky;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (Rx_VALID) begin
          if (byte_bad) begin
            digits_nxt = {4{ERR_CODE}};
            err_nxt    = 1'b1;
            sticky_nxt = 1'b1;
          end else begin
            high_nxt  = Rx_DATA;
            cnt_clear = 1'b1;
            state_nxt = WAIT_LOW;
          end
        end
      end
      WAIT_LOW: begin
        // A strobe in the expiry cycle still completes the frame.
        if (Rx_VALID) begin
          state_nxt = IDLE;
          if (byte_bad) begin
            digits_nxt = {4{ERR_CODE}};
            err_nxt    = 1'b1;
            sticky_nxt = 1'b1;
          end else begin
            digits_nxt = bit_reverse16({high_byte, Rx_DATA});
            done_nxt   = 1'b1;
            sticky_nxt = 1'b0;
          end
        end else if (expired) begin
          err_nxt    = 1'b1;
          sticky_nxt = 1'b1;
          state_nxt  = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign digit3 = digits[15:12];
  assign digit2 = digits[11:8];
  assign digit1 = digits[7:4];
  assign digit0 = digits[3:0];
  assign busy   = (state == WAIT_LOW);

endmodule
